// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet parser: FSM encoding, default framing constants, LEN field width.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_HOLD
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         DEF_MAX_LEN   = 4;
    localparam int         LEN_W         = 3;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer: counts while enabled, restarts on clear.
// Latency: expire is combinational from the count register (same cycle the count hits the limit).
// Backpressure: none; clear always wins over counting.
module uart_byte_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int             CW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Held at zero outside packet states so a later packet never inherits a stale count.
    always_ff @(posedge clk) begin
        if (!resetn || clear || !enable) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_pkt_parser.sv
// Decodes SYNC/CMD/LEN/payload/CSUM frames from a UART byte stream into a held packet.
// Latency: pkt_valid rises one cycle after the CSUM byte; error pulses one cycle after their cause.
// Backpressure: packet held until pkt_ready; bytes arriving while held are dropped with err_overrun.
module uart_pkt_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN        = DEF_MAX_LEN,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   rx_break,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [7:0]             pkt_cmd,
    output logic [LEN_W-1:0]       pkt_len,
    output logic [8*MAX_LEN-1:0]   pkt_payload,
    output logic                   err_checksum,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic                   err_overrun
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state;
    logic [7:0]       xor_acc;
    logic [LEN_W-1:0] idx;
    logic             timer_en;
    logic             timer_expire;

    assign timer_en = (state == ST_CMD) || (state == ST_LEN) ||
                      (state == ST_PAYLOAD) || (state == ST_CSUM);

    uart_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (rx_valid),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            xor_acc      <= '0;
            idx          <= '0;
            pkt_valid    <= 1'b0;
            pkt_cmd      <= '0;
            pkt_len      <= '0;
            pkt_payload  <= '0;
            err_checksum <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;

            // Break aborts silently and outranks a same-cycle byte; a held packet is immune.
            if (rx_break && state != ST_HOLD) begin
                state <= ST_IDLE;
            end else if (timer_expire) begin
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            pkt_payload <= '0;
                            pkt_len     <= '0;
                            state       <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            pkt_cmd <= rx_data;
                            xor_acc <= rx_data;
                            state   <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            xor_acc <= xor_acc ^ rx_data;
                            idx     <= '0;
                            if (rx_data > MAX_LEN_B) begin
                                err_len <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                pkt_len <= rx_data[LEN_W-1:0];
                                state   <= (rx_data == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_valid) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (idx == LEN_W'(i)) begin
                                    pkt_payload[8*i +: 8] <= rx_data;
                                end
                            end
                            xor_acc <= xor_acc ^ rx_data;
                            idx     <= idx + LEN_W'(1);
                            if (idx == pkt_len - LEN_W'(1)) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == xor_acc) begin
                                pkt_valid <= 1'b1;
                                state     <= ST_HOLD;
                            end else begin
                                err_checksum <= 1'b1;
                                state        <= ST_IDLE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (rx_valid) begin
                            err_overrun <= 1'b1;
                        end
                        if (pkt_ready) begin
                            pkt_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser with a short timeout so the silence case stays brief.
module tb_uart_pkt_parser;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_break;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_cmd;
    logic [2:0]  pkt_len;
    logic [31:0] pkt_payload;
    logic        err_checksum, err_len, err_timeout, err_overrun;
    logic [3:0]  errs;

    int checks   = 0;
    int failures = 0;

    assign errs = {err_checksum, err_len, err_timeout, err_overrun};

    uart_pkt_parser #(
        .MAX_LEN        (4),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_break     (rx_break),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_cmd      (pkt_cmd),
        .pkt_len      (pkt_len),
        .pkt_payload  (pkt_payload),
        .err_checksum (err_checksum),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte is held across one rising edge; returns 1 time unit after that edge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic brk();
        rx_break = 1'b1;
        @(posedge clk);
        #1;
        rx_break = 1'b0;
    endtask

    task automatic xfer();
        pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        pkt_ready = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_break  = 1'b0;
        pkt_ready = 1'b0;
        idle(3);
        chk("rst_valid",   pkt_valid,   0);
        chk("rst_cmd",     pkt_cmd,     0);
        chk("rst_len",     pkt_len,     0);
        chk("rst_payload", pkt_payload, 0);
        chk("rst_errs",    errs,        0);
        resetn = 1'b1;
        idle(2);

        // Basic two-byte packet
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44);
        chk("basic_pre_valid", pkt_valid, 0);
        send(8'h65);
        chk("basic_valid",   pkt_valid,   1);
        chk("basic_cmd",     pkt_cmd,     8'h10);
        chk("basic_len",     pkt_len,     2);
        chk("basic_payload", pkt_payload, 32'h0000_4433);
        chk("basic_errs",    errs,        0);
        xfer();
        chk("basic_after_xfer", pkt_valid, 0);

        // Bad checksum, then a good packet
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h66);
        chk("csum_pulse", errs,      4'b1000);
        chk("csum_valid", pkt_valid, 0);
        idle(1);
        chk("csum_single", errs, 0);
        send(8'hA5); send(8'h20); send(8'h01); send(8'h7E); send(8'h5F);
        chk("recov_valid",   pkt_valid,   1);
        chk("recov_cmd",     pkt_cmd,     8'h20);
        chk("recov_len",     pkt_len,     1);
        chk("recov_payload", pkt_payload, 32'h0000_007E);
        xfer();

        // Garbage before sync, zero-length packet
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("garbage_errs", errs, 0);
        send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
        chk("zl_valid",   pkt_valid,   1);
        chk("zl_cmd",     pkt_cmd,     8'h07);
        chk("zl_len",     pkt_len,     0);
        chk("zl_payload", pkt_payload, 0);
        xfer();

        // Over-length LEN
        send(8'hA5); send(8'h10); send(8'h05);
        chk("len_pulse", errs, 4'b0100);
        idle(1);
        chk("len_single", errs, 0);

        // Timeout after CMD: pulse lands exactly TO cycles after the last byte's edge
        send(8'hA5); send(8'h10);
        idle(TO - 1);
        chk("to_early", errs, 0);
        idle(1);
        chk("to_pulse", errs, 4'b0010);
        idle(1);
        chk("to_single", errs, 0);
        // Back in IDLE these are ignored; stuck in LEN they would give a checksum error
        send(8'h00); send(8'h00);
        idle(1);
        chk("to_idle_errs",  errs,      0);
        chk("to_idle_valid", pkt_valid, 0);

        // Overrun while held
        send(8'hA5); send(8'h3C); send(8'h01); send(8'hAA); send(8'h97);
        chk("hold_valid", pkt_valid, 1);
        idle(5);
        send(8'h3C);
        chk("ovr_pulse",   errs,        4'b0001);
        chk("ovr_valid",   pkt_valid,   1);
        chk("ovr_cmd",     pkt_cmd,     8'h3C);
        chk("ovr_payload", pkt_payload, 32'h0000_00AA);
        idle(14);
        chk("hold_still",   pkt_valid, 1);
        chk("hold_errs",    errs,      0);
        xfer();
        chk("hold_released", pkt_valid, 0);

        // Byte on the transfer cycle is still an overrun
        send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
        chk("xo_valid", pkt_valid, 1);
        pkt_ready = 1'b1;
        send(8'h55);
        pkt_ready = 1'b0;
        chk("xo_pulse", errs,      4'b0001);
        chk("xo_valid_after", pkt_valid, 0);

        // Break mid-packet aborts silently
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33);
        brk();
        chk("brk_errs", errs, 0);
        send(8'h44); send(8'h65);
        chk("brk_no_pkt", pkt_valid, 0);
        chk("brk_no_err", errs,      0);

        // Break in HOLD ignored
        send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
        brk();
        chk("brk_hold_valid", pkt_valid, 1);
        chk("brk_hold_cmd",   pkt_cmd,   8'h01);
        xfer();

        // Reset mid-packet
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33);
        resetn = 1'b0;
        idle(1);
        chk("mrst_valid",   pkt_valid,   0);
        chk("mrst_cmd",     pkt_cmd,     0);
        chk("mrst_payload", pkt_payload, 0);
        chk("mrst_errs",    errs,        0);
        resetn = 1'b1;
        send(8'h44); send(8'h65);
        chk("mrst_no_pkt", pkt_valid, 0);

        // Reset in HOLD
        send(8'hA5); send(8'h22); send(8'h01); send(8'h11); send(8'h32);
        chk("hrst_pre", pkt_valid, 1);
        resetn = 1'b0;
        idle(1);
        chk("hrst_valid", pkt_valid, 0);
        chk("hrst_len",   pkt_len,   0);
        chk("hrst_errs",  errs,      0);
        resetn = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_pkt_parser.md
UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 4, maximum payload bytes per packet (1..7).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, maximum idle clk cycles allowed between bytes inside a packet.
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port rx_valid  in  1  one-cycle strobe, received byte available.
REQ-007 SHALL have port rx_data  in  8  received byte, sampled when rx_valid=1.
REQ-008 SHALL have port rx_break  in  1  one-cycle strobe, line BREAK detected.
REQ-009 SHALL have port pkt_valid  out  1  decoded packet available.
REQ-010 SHALL have port pkt_ready  in  1  consumer accepts packet.
REQ-011 SHALL have port pkt_cmd  out  8  command byte.
REQ-012 SHALL have port pkt_len  out  3  payload byte count.
REQ-013 SHALL have port pkt_payload  out  8*MAX_LEN  payload; byte i at bits [8i+7:8i]; unused bytes zero.
REQ-014 SHALL have ports err_checksum, err_len, err_timeout, err_overrun  out  1 each  one-cycle error pulses.

Function
REQ-015 Packet format SHALL be SYNC, CMD, LEN, LEN payload bytes, CSUM; CSUM = XOR of CMD, LEN and all payload bytes.
REQ-016 FSM states SHALL be IDLE, CMD, LEN, PAYLOAD, CSUM, HOLD.
REQ-017 IDLE: rx_valid with SYNC_BYTE -> CMD; any other byte ignored, no error.
REQ-018 CMD: byte stored as cmd, running XOR initialised to it -> LEN.
REQ-019 LEN: LEN > MAX_LEN -> err_len pulse, IDLE; LEN = 0 -> CSUM; else -> PAYLOAD; XOR updated.
REQ-020 PAYLOAD: each byte written at index 0..LEN-1 in arrival order, XOR updated; after byte LEN-1 -> CSUM.
REQ-021 CSUM: match -> HOLD; mismatch -> err_checksum pulse, IDLE.
REQ-022 pkt_valid SHALL assert the cycle after the CSUM byte's rx_valid cycle (latency 1).
REQ-023 HOLD: pkt_valid=1; pkt_cmd/len/payload stable while pkt_valid=1 and pkt_ready=0.
REQ-024 Transfer SHALL occur on pkt_valid=1 and pkt_ready=1; next cycle pkt_valid=0, state IDLE.
REQ-025 rx_valid in HOLD, including the transfer cycle, SHALL drop the byte and pulse err_overrun.
REQ-026 Byte timer SHALL clear on every rx_valid and count only in CMD, LEN, PAYLOAD, CSUM.
REQ-027 Timer reaching TIMEOUT_CYCLES-1 with no rx_valid that cycle SHALL pulse err_timeout and go IDLE.
REQ-028 rx_break in any state except HOLD SHALL abort to IDLE, no error pulse; rx_break has priority over simultaneous rx_valid.
REQ-029 rx_break in HOLD SHALL be ignored.
REQ-030 Entering CMD SHALL zero the payload buffer and length.
REQ-031 Error pulses SHALL last exactly one cycle; pulses are mutually exclusive per cycle.

Reset
REQ-032 resetn=0 SHALL force state IDLE, timer 0, XOR 0, buffer 0.
REQ-033 Reset values SHALL be 0 for pkt_valid, pkt_cmd, pkt_len, pkt_payload and all err_* outputs.
REQ-034 Reset mid-packet or in HOLD SHALL discard the packet without pulsing any error.

Structure
REQ-035 Shared package uart_pkg SHALL hold the FSM state encoding, default SYNC_BYTE, default MAX_LEN and LEN field width.
REQ-036 Inter-byte timeout counter SHALL be sub-module uart_byte_timer (clear, enable, expire pulse).

Verification
REQ-037 A5 10 02 33 44 65 -> one cycle after 65: pkt_valid=1, cmd=10, len=2, payload=32'h0000_4433.
REQ-038 A5 10 02 33 44 66 -> err_checksum single pulse; pkt_valid stays 0; next valid packet still decoded.
REQ-039 00 FF 5A A5 07 00 07 -> garbage ignored; pkt_valid with cmd=07, len=0, payload=0.
REQ-040 A5 10 05 -> err_len pulse after 05; A5 10 then silence TIMEOUT_CYCLES -> err_timeout pulse, state IDLE.
REQ-041 Valid packet, pkt_ready=0 for 20 cycles, byte 3C sent meanwhile -> err_overrun pulse, outputs unchanged; pkt_ready=1 -> transfer, pkt_valid=0 next cycle.
REQ-042 A5 10 02 33 then rx_break -> IDLE, no pulse; resetn=0 mid-packet -> all outputs 0.
